// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master round-robin arbiter for the global Wishbone bus.
// Master 0 is the hostbus gateway and master 1 is a second on-chip master.
// A grant is held for a whole bus cycle. There is always at least one idle
// clock between two grants. A watchdog ends stalled strobes with a one-cycle
// error pulse to the owning master, and the grant is kept after the error.
module wb_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255,
    parameter int TO_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cycle0,
    input  logic                  strobe0,
    input  logic                  write0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wrData0,
    output logic [DATA_WIDTH-1:0] rdData0,
    output logic                  ack0,
    output logic                  err0,
    output logic                  gnt0,

    input  logic                  cycle1,
    input  logic                  strobe1,
    input  logic                  write1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wrData1,
    output logic [DATA_WIDTH-1:0] rdData1,
    output logic                  ack1,
    output logic                  err1,
    output logic                  gnt1,

    output logic                  glob_cycle,
    output logic                  glob_strobe,
    output logic                  glob_write,
    output logic [ADDR_WIDTH-1:0] glob_addr,
    output logic [DATA_WIDTH-1:0] glob_wrData,
    input  logic [DATA_WIDTH-1:0] glob_rdData,
    input  logic                  slv_ack
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    // Count value at which a stalled strobe is terminated on the next edge.
    localparam logic [TO_WIDTH-1:0] WD_LIMIT = TO_WIDTH'(TIMEOUT - 1);

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic                last;
    logic                last_next;
    logic [TO_WIDTH-1:0] wd;
    logic                wd_run;
    logic                wd_hit;

    // Arbitration: grants are issued only from IDLE, and a tie goes to the
    // master that was not served last.
    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (cycle0 && (!cycle1 || last)) begin
                    state_next = GNT0;
                    last_next  = 1'b0;
                end else if (cycle1) begin
                    state_next = GNT1;
                    last_next  = 1'b1;
                end
            end
            GNT0: begin
                if (!cycle0) begin
                    state_next = IDLE;
                end
            end
            GNT1: begin
                if (!cycle1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and last-served registers. last resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    assign gnt0 = (state == GNT0);
    assign gnt1 = (state == GNT1);

    // Downstream mux: the owner's request drives the bus, and IDLE drives all zeros.
    always_comb begin
        glob_cycle  = 1'b0;
        glob_strobe = 1'b0;
        glob_write  = 1'b0;
        glob_addr   = '0;
        glob_wrData = '0;
        if (gnt0) begin
            glob_cycle  = cycle0;
            glob_strobe = strobe0;
            glob_write  = write0;
            glob_addr   = addr0;
            glob_wrData = wrData0;
        end else if (gnt1) begin
            glob_cycle  = cycle1;
            glob_strobe = strobe1;
            glob_write  = write1;
            glob_addr   = addr1;
            glob_wrData = wrData1;
        end
    end

    // Response routing: only the owning master sees ack and read data.
    always_comb begin
        ack0    = slv_ack & gnt0 & strobe0;
        ack1    = slv_ack & gnt1 & strobe1;
        rdData0 = gnt0 ? glob_rdData : '0;
        rdData1 = gnt1 ? glob_rdData : '0;
    end

    // The watchdog counts only while a granted strobe waits without an ack.
    // An ack in the limit cycle stops the error from firing.
    assign wd_run = (gnt0 | gnt1) & glob_strobe & ~slv_ack;
    assign wd_hit = (wd == WD_LIMIT);

    // Watchdog counter and one-cycle error pulse to the current owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd   <= '0;
            err0 <= 1'b0;
            err1 <= 1'b0;
        end else begin
            err0 <= 1'b0;
            err1 <= 1'b0;
            if (!wd_run) begin
                wd <= '0;
            end else if (wd_hit) begin
                wd   <= '0;
                err0 <= gnt0;
                err1 <= gnt1;
            end else if (wd != '1) begin
                wd <= wd + TO_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: the stimulus pushes hand-computed output
// snapshots, and a negedge monitor pops each snapshot and compares it with the DUT.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c0, s0, w0, c1, s1, w1;
    logic [15:0] a0, d0, a1, d1;
    logic [15:0] rd0, rd1;
    logic        ack0, ack1, err0, err1, gnt0, gnt1;
    logic        g_cyc, g_stb, g_wr;
    logic [15:0] g_addr, g_wd, g_rd;
    logic        sack;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [72:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [72:0] act;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16),
        .TIMEOUT(4),
        .TO_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cycle0(c0), .strobe0(s0), .write0(w0), .addr0(a0), .wrData0(d0),
        .rdData0(rd0), .ack0(ack0), .err0(err0), .gnt0(gnt0),
        .cycle1(c1), .strobe1(s1), .write1(w1), .addr1(a1), .wrData1(d1),
        .rdData1(rd1), .ack1(ack1), .err1(err1), .gnt1(gnt1),
        .glob_cycle(g_cyc), .glob_strobe(g_stb), .glob_write(g_wr),
        .glob_addr(g_addr), .glob_wrData(g_wd), .glob_rdData(g_rd),
        .slv_ack(sack)
    );

    // Monitor: one snapshot per cycle, compared at the falling edge.
    always @(negedge clk) begin
        act = {gnt0, gnt1, ack0, ack1, err0, err1, g_cyc, g_stb, g_wr,
               g_addr, g_wd, rd0, rd1};
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (act !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h (gnt0 gnt1 ack0 ack1 err0 err1 cyc stb wr | addr wd rd0 rd1)",
                         e.tag, act, e.val);
            end
        end else begin
            checks++;
            if ({ack0, ack1, err0, err1} !== 4'b0000) begin
                failures++;
                $display("FAIL unsolicited: got ack/err %b expected 0000", {ack0, ack1, err0, err1});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ctl bits: gnt0 gnt1 ack0 ack1 err0 err1 glob_cycle glob_strobe glob_write
    task automatic expect_v(input string tag, input logic [8:0] ctl,
                            input logic [15:0] ad, input logic [15:0] wd,
                            input logic [15:0] r0, input logic [15:0] r1);
        exp_t x;
        x.tag = tag;
        x.val = {ctl, ad, wd, r0, r1};
        sb.push_back(x);
    endtask

    task automatic expect0(input string tag);
        expect_v(tag, 9'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; sack = 1'b0; g_rd = '0;
        c0 = 0; s0 = 0; w0 = 0; a0 = '0; d0 = '0;
        c1 = 0; s1 = 0; w1 = 0; a1 = '0; d1 = '0;

        // Reset: outputs stay quiet even with requests and ack present
        tick(); rst = 1; c0 = 1; s0 = 1; sack = 1; g_rd = 16'hFFFF; a0 = 16'h0012;
        expect0("rst_hold");
        tick(); rst = 0; c0 = 0; s0 = 0; sack = 0; g_rd = '0; a0 = '0;
        expect0("rst_rel");

        // Tie after reset goes to master 0, then master 1 after one idle clock
        tick(); c0 = 1; c1 = 1; a0 = 16'h0100; a1 = 16'h0200;
        expect0("tie_req");
        tick(); expect_v("tie_gnt0", 9'b10_00_00_100, 16'h0100, 16'h0, 16'h0, 16'h0);
        tick(); c0 = 0;
        expect_v("tie_rel0", 9'b10_00_00_000, 16'h0100, 16'h0, 16'h0, 16'h0);
        tick(); expect0("tie_gap");
        tick(); c0 = 1;
        expect_v("tie_gnt1", 9'b01_00_00_100, 16'h0200, 16'h0, 16'h0, 16'h0);
        tick(); c1 = 0;
        expect_v("tie_rel1", 9'b01_00_00_000, 16'h0200, 16'h0, 16'h0, 16'h0);
        tick(); c1 = 1;
        expect0("tie2_gap");
        tick(); expect_v("tie2_gnt0", 9'b10_00_00_100, 16'h0100, 16'h0, 16'h0, 16'h0);
        tick(); c0 = 0; c1 = 0;
        expect_v("tie2_rel0", 9'b10_00_00_000, 16'h0100, 16'h0, 16'h0, 16'h0);
        tick(); expect0("tie2_idle");

        // Single-master write
        tick(); c0 = 1; s0 = 1; w0 = 1; a0 = 16'h0012; d0 = 16'hBEEF;
        expect0("wr_req");
        tick(); expect_v("wr_gnt", 9'b10_00_00_111, 16'h0012, 16'hBEEF, 16'h0, 16'h0);
        tick(); sack = 1; g_rd = 16'h5555;
        expect_v("wr_ack", 9'b10_10_00_111, 16'h0012, 16'hBEEF, 16'h5555, 16'h0);
        tick(); sack = 0; g_rd = '0; c0 = 0; s0 = 0; w0 = 0;
        expect_v("wr_rel", 9'b10_00_00_000, 16'h0012, 16'hBEEF, 16'h0, 16'h0);
        tick(); expect0("wr_idle");

        // Read routing to master 1
        tick(); c1 = 1; s1 = 1; a1 = 16'h0300; g_rd = 16'h1234; d0 = '0;
        expect0("rd_req");
        tick(); sack = 1; s0 = 1;
        expect_v("rd_ack", 9'b01_01_00_110, 16'h0300, 16'h0, 16'h0, 16'h1234);
        tick(); sack = 0; g_rd = '0; s0 = 0; c1 = 0; s1 = 0;
        expect_v("rd_rel", 9'b01_00_00_000, 16'h0300, 16'h0, 16'h0, 16'h0);
        tick(); expect0("rd_idle");

        // Watchdog: stalled strobe errors four clocks after the grant
        tick(); c0 = 1; s0 = 1; a0 = 16'h0040;
        expect0("wd_req");
        for (int i = 0; i < 4; i++) begin
            tick(); expect_v("wd_wait", 9'b10_00_00_110, 16'h0040, 16'h0, 16'h0, 16'h0);
        end
        tick(); expect_v("wd_err", 9'b10_00_10_110, 16'h0040, 16'h0, 16'h0, 16'h0);
        tick(); expect_v("wd_hold", 9'b10_00_00_110, 16'h0040, 16'h0, 16'h0, 16'h0);
        tick(); c0 = 0; s0 = 0;
        expect_v("wd_rel", 9'b10_00_00_000, 16'h0040, 16'h0, 16'h0, 16'h0);
        tick(); expect0("wd_idle");

        // Ack in the limit cycle beats the timeout
        tick(); c0 = 1; s0 = 1; a0 = 16'h0044;
        expect0("wa_req");
        for (int i = 0; i < 3; i++) begin
            tick(); expect_v("wa_wait", 9'b10_00_00_110, 16'h0044, 16'h0, 16'h0, 16'h0);
        end
        tick(); sack = 1;
        expect_v("wa_ack4", 9'b10_10_00_110, 16'h0044, 16'h0, 16'h0, 16'h0);
        tick(); sack = 0;
        expect_v("wa_noerr", 9'b10_00_00_110, 16'h0044, 16'h0, 16'h0, 16'h0);
        tick(); expect_v("wa_cont", 9'b10_00_00_110, 16'h0044, 16'h0, 16'h0, 16'h0);
        tick(); c0 = 0; s0 = 0;
        expect_v("wa_rel", 9'b10_00_00_000, 16'h0044, 16'h0, 16'h0, 16'h0);
        tick(); expect0("wa_idle");

        // Reset while master 1 owns the bus
        tick(); c1 = 1; s1 = 1; w1 = 1; a1 = 16'h0500; d1 = 16'hCAFE;
        expect0("mr_req");
        tick(); rst = 1; c0 = 1; a0 = 16'h0600;
        expect_v("mr_busy", 9'b01_00_00_111, 16'h0500, 16'hCAFE, 16'h0, 16'h0);
        tick(); rst = 0; sack = 1;
        expect0("mr_after");
        tick(); sack = 0;
        expect_v("mr_tie0", 9'b10_00_00_100, 16'h0600, 16'h0, 16'h0, 16'h0);
        tick(); c0 = 0; c1 = 0; s1 = 0; w1 = 0;
        expect_v("mr_rel0", 9'b10_00_00_000, 16'h0600, 16'h0, 16'h0, 16'h0);
        tick(); expect0("mr_idle");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
